// File: rtl/fpu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fpu_issue_arbiter
// Brief   : Round-robin sharing of one FPU port between NUM_REQ requesters,
//           with tag-based result routing and per-requester in-flight limits.
// Rev     : 1.0
// ============================================================================
module fpu_issue_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int UTAG_W    = 4,
    parameter int PAYLOAD_W = 256,
    parameter int RESULT_W  = 69,
    parameter int MAX_OUTST = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]  req_payload_i,
    input  logic [NUM_REQ*UTAG_W-1:0]     req_utag_i,
    output logic                          fpu_valid_o,
    input  logic                          fpu_ready_i,
    output logic [PAYLOAD_W-1:0]          fpu_payload_o,
    output logic [ID_W+UTAG_W-1:0]        fpu_tag_o,
    input  logic                          fpu_rvalid_i,
    output logic                          fpu_rready_o,
    input  logic [RESULT_W-1:0]           fpu_result_i,
    input  logic [ID_W+UTAG_W-1:0]        fpu_rtag_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    input  logic [NUM_REQ-1:0]            rsp_ready_i,
    output logic [RESULT_W-1:0]           rsp_result_o,
    output logic [UTAG_W-1:0]             rsp_utag_o,
    output logic                          busy_o
);

    localparam int               TAG_W       = ID_W + UTAG_W;
    localparam int               CNT_W       = $clog2(MAX_OUTST + 1);
    localparam int               NUM_SLOT    = 1 << ID_W;
    localparam logic [CNT_W-1:0] C_MAX_OUTST = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [ID_W-1:0]  C_ID_ONE    = ID_W'(1);
    localparam logic [ID_W-1:0]  C_LAST_IDX  = ID_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     w_rr_ptr_nxt;
    logic [ID_W-1:0]     r_lock_idx;
    logic [ID_W-1:0]     w_lock_idx_nxt;
    logic [CNT_W-1:0]    r_outst_cnt [NUM_REQ];

    logic [NUM_REQ-1:0]  w_eligible;
    logic [NUM_REQ-1:0]  w_cnt_nz;
    logic [NUM_REQ-1:0]  w_issue;
    logic [NUM_REQ-1:0]  w_retire;
    logic [ID_W-1:0]     w_rr_grant;
    logic [ID_W-1:0]     w_grant;
    logic                w_any_elig;
    logic                w_fpu_valid;
    logic                w_issue_hs;

    logic [ID_W-1:0]     w_rsp_idx;
    logic [NUM_SLOT-1:0] w_rsp_ready_pad;
    logic [NUM_SLOT-1:0] w_rsp_onehot;
    logic                w_rready;
    logic                w_rsp_hs;

    always_comb begin
        w_eligible = '0;
        w_cnt_nz   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_eligible[i] = req_valid_i[i] && (r_outst_cnt[i] < C_MAX_OUTST);
            w_cnt_nz[i]   = (r_outst_cnt[i] != '0);
        end
    end

    // Scan from the highest offset down so the nearest eligible index wins.
    always_comb begin
        int scan_idx;
        scan_idx   = 0;
        w_any_elig = 1'b0;
        w_rr_grant = r_rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (w_eligible[scan_idx]) begin
                w_any_elig = 1'b1;
                w_rr_grant = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_lock_idx_nxt = r_lock_idx;
        w_grant        = (r_state == ST_HOLD) ? r_lock_idx : w_rr_grant;
        w_fpu_valid    = !flush_i && ((r_state == ST_HOLD) || w_any_elig);
        w_issue_hs     = w_fpu_valid && fpu_ready_i;
        if (flush_i) begin
            w_state_nxt = ST_ARB;
        end else if (w_issue_hs) begin
            w_state_nxt  = ST_ARB;
            w_rr_ptr_nxt = (w_grant == C_LAST_IDX) ? '0 : (w_grant + C_ID_ONE);
        end else if (w_fpu_valid) begin
            // Offered but not taken: pin the grant until the FPU accepts it.
            w_state_nxt    = ST_HOLD;
            w_lock_idx_nxt = w_grant;
        end
    end

    assign w_rsp_idx       = fpu_rtag_i[TAG_W-1:UTAG_W];
    assign w_rsp_ready_pad = NUM_SLOT'(rsp_ready_i);
    assign w_rsp_onehot    = NUM_SLOT'(1) << w_rsp_idx;
    assign w_rready        = flush_i || w_rsp_ready_pad[w_rsp_idx];
    assign w_rsp_hs        = fpu_rvalid_i && w_rready && !flush_i;

    always_comb begin
        w_issue  = '0;
        w_retire = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_issue[i]  = w_issue_hs && (w_grant == ID_W'(i));
            w_retire[i] = w_rsp_hs && (w_rsp_idx == ID_W'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_ARB;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_outst_cnt[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_lock_idx <= w_lock_idx_nxt;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (flush_i) begin
                    r_outst_cnt[i] <= '0;
                end else if (w_issue[i] && !w_retire[i]) begin
                    r_outst_cnt[i] <= r_outst_cnt[i] + C_CNT_ONE;
                end else if (w_retire[i] && !w_issue[i] && w_cnt_nz[i]) begin
                    r_outst_cnt[i] <= r_outst_cnt[i] - C_CNT_ONE;
                end
            end
        end
    end

    // Handshake outputs are forced low while reset is asserted.
    assign fpu_valid_o   = rst_ni && w_fpu_valid;
    assign req_ready_o   = rst_ni ? w_issue : '0;
    assign fpu_payload_o = req_payload_i[int'(w_grant)*PAYLOAD_W +: PAYLOAD_W];
    assign fpu_tag_o     = {w_grant, req_utag_i[int'(w_grant)*UTAG_W +: UTAG_W]};
    assign fpu_rready_o  = rst_ni && w_rready;
    assign rsp_valid_o   = (rst_ni && fpu_rvalid_i && !flush_i) ? w_rsp_onehot[NUM_REQ-1:0] : '0;
    assign rsp_result_o  = fpu_result_i;
    assign rsp_utag_o    = fpu_rtag_i[UTAG_W-1:0];
    assign busy_o        = rst_ni && (|w_cnt_nz);

`ifndef SYNTHESIS
    a_hold_valid_kept: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state == ST_HOLD && !flush_i) |-> req_valid_i[r_lock_idx]);

    a_no_rsp_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(|(w_retire & ~w_cnt_nz)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpu_issue_arbiter
// Brief   : Scoreboard bench for fpu_issue_arbiter against a transaction-level
//           reference model of the arbitration and routing rules.
// Rev     : 1.0
// ============================================================================
module tb_fpu_issue_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int ID_W      = 1;
    localparam int UTAG_W    = 4;
    localparam int PAYLOAD_W = 256;
    localparam int RESULT_W  = 69;
    localparam int MAX_OUTST = 4;
    localparam int TAG_W     = ID_W + UTAG_W;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         flush = 1'b0;
    logic [NUM_REQ-1:0]           vld = '0;
    logic [NUM_REQ-1:0]           req_ready;
    logic [PAYLOAD_W-1:0]         pay [NUM_REQ];
    logic [UTAG_W-1:0]            ut  [NUM_REQ];
    logic [NUM_REQ*PAYLOAD_W-1:0] req_payload;
    logic [NUM_REQ*UTAG_W-1:0]    req_utag;
    logic                         fpu_valid;
    logic                         fready = 1'b0;
    logic [PAYLOAD_W-1:0]         fpu_payload;
    logic [TAG_W-1:0]             fpu_tag;
    logic                         rvalid = 1'b0;
    logic                         fpu_rready;
    logic [RESULT_W-1:0]          rres = '0;
    logic [TAG_W-1:0]             rtag = '0;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [NUM_REQ-1:0]           rsp_rdy = '0;
    logic [RESULT_W-1:0]          rsp_result;
    logic [UTAG_W-1:0]            rsp_utag;
    logic                         busy;

    always #5 clk = ~clk;

    always_comb begin
        req_payload = '0;
        req_utag    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_payload[i*PAYLOAD_W +: PAYLOAD_W] = pay[i];
            req_utag[i*UTAG_W +: UTAG_W]          = ut[i];
        end
    end

    fpu_issue_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .UTAG_W(UTAG_W),
        .PAYLOAD_W(PAYLOAD_W), .RESULT_W(RESULT_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(vld), .req_ready_o(req_ready),
        .req_payload_i(req_payload), .req_utag_i(req_utag),
        .fpu_valid_o(fpu_valid), .fpu_ready_i(fready),
        .fpu_payload_o(fpu_payload), .fpu_tag_o(fpu_tag),
        .fpu_rvalid_i(rvalid), .fpu_rready_o(fpu_rready),
        .fpu_result_i(rres), .fpu_rtag_i(rtag),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_rdy),
        .rsp_result_o(rsp_result), .rsp_utag_o(rsp_utag),
        .busy_o(busy)
    );

    typedef struct packed {
        logic               fv;
        logic [NUM_REQ-1:0] rr;
        logic               rrdy;
        logic [NUM_REQ-1:0] rv;
        logic               busy;
    } cyc_t;
    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [PAYLOAD_W-1:0] pay;
    } iss_t;
    typedef struct packed {
        logic [NUM_REQ-1:0]  rv;
        logic [UTAG_W-1:0]   ut;
        logic [RESULT_W-1:0] res;
    } rsp_t;

    cyc_t             cyc_q [$];
    iss_t             issue_q [$];
    rsp_t             rsp_q [$];
    logic [TAG_W-1:0] inflight [$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: round-robin pointer, per-requester in-flight counts,
    // and whether an offered request is pinned waiting for the FPU.
    int m_rr = 0;
    int m_cnt [NUM_REQ];
    bit m_hold = 1'b0;
    int m_lock = 0;
    bit e_issue;
    bit e_rsp;
    int e_g;

    int p_req = 0, p_fr = 0, p_rv = 0, p_rr = 0, p_fl = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT output with no expected entry at %0t", name, $time);
    endtask

    task automatic new_op(input int i, input logic [UTAG_W-1:0] tag);
        vld[i] = 1'b1;
        ut[i]  = tag;
        for (int w = 0; w < PAYLOAD_W / 32; w++) pay[i][w*32 +: 32] = $urandom;
    endtask

    task automatic step();
        int   g;
        int   d;
        bit   found;
        bit   exp_v;
        bit   exp_rrdy;
        cyc_t c;
        logic [NUM_REQ-1:0] oh;
        found = 1'b0;
        g     = 0;
        if (m_hold) begin
            found = 1'b1;
            g     = m_lock;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int idx;
                idx = (m_rr + k) % NUM_REQ;
                if (!found && vld[idx] && m_cnt[idx] < MAX_OUTST) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
        end
        exp_v    = found && !flush;
        e_issue  = exp_v && fready;
        e_g      = g;
        d        = int'(rtag[TAG_W-1:UTAG_W]);
        exp_rrdy = flush ? 1'b1 : rsp_rdy[d];
        e_rsp    = rvalid && exp_rrdy && !flush;
        oh       = '0;
        oh[d]    = 1'b1;
        c.fv     = exp_v;
        c.rr     = '0;
        if (e_issue) c.rr[g] = 1'b1;
        c.rrdy   = exp_rrdy;
        c.rv     = (rvalid && !flush) ? oh : '0;
        c.busy   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) if (m_cnt[i] != 0) c.busy = 1'b1;
        cyc_q.push_back(c);
        if (e_issue) issue_q.push_back({ID_W'(g), ut[g], pay[g]});
        if (rvalid && !flush) rsp_q.push_back({oh, rtag[UTAG_W-1:0], rres});
        @(posedge clk);
        if (flush) begin
            for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
            m_hold = 1'b0;
        end else begin
            if (e_issue) begin
                m_cnt[g]++;
                m_rr   = (g + 1) % NUM_REQ;
                m_hold = 1'b0;
            end else if (exp_v) begin
                m_hold = 1'b1;
                m_lock = g;
            end
            if (e_rsp && m_cnt[d] > 0) m_cnt[d]--;
        end
        #1;
    endtask

    task automatic post();
        if (e_issue) begin
            inflight.push_back({ID_W'(e_g), ut[e_g]});
            if ($urandom_range(99) < p_req) new_op(e_g, UTAG_W'($urandom));
            else vld[e_g] = 1'b0;
        end
        if (flush) begin
            inflight.delete();
            rvalid = 1'b0;
        end else if (e_rsp) begin
            for (int k = 0; k < inflight.size(); k++) begin
                if (inflight[k] == rtag) begin
                    inflight.delete(k);
                    break;
                end
            end
            rvalid = 1'b0;
        end
    endtask

    task automatic gen();
        for (int i = 0; i < NUM_REQ; i++)
            if (!vld[i] && $urandom_range(99) < p_req) new_op(i, UTAG_W'($urandom));
        fready = ($urandom_range(99) < p_fr);
        if (!rvalid && inflight.size() > 0 && $urandom_range(99) < p_rv) begin
            rvalid = 1'b1;
            rtag   = inflight[$urandom_range(inflight.size() - 1)];
            rres   = RESULT_W'({$urandom, $urandom, $urandom});
        end
        for (int i = 0; i < NUM_REQ; i++) rsp_rdy[i] = ($urandom_range(99) < p_rr);
        flush = ($urandom_range(99) < p_fl);
    endtask

    task automatic tick();
        step();
        post();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            gen();
            tick();
        end
    endtask

    task automatic drain();
        p_req = 0; p_fr = 100; p_rv = 100; p_rr = 100; p_fl = 0;
        for (int k = 0; k < 60; k++) begin
            if (inflight.size() == 0 && !rvalid && vld == '0) break;
            run(1);
        end
    endtask

    // Monitor: compares whatever the DUT presents against queued expectations.
    initial begin
        cyc_t c;
        iss_t s;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                check("fpu_valid_o", 256'(fpu_valid), 256'(c.fv));
                check("req_ready_o", 256'(req_ready), 256'(c.rr));
                check("fpu_rready_o", 256'(fpu_rready), 256'(c.rrdy));
                check("rsp_valid_o", 256'(rsp_valid), 256'(c.rv));
                check("busy_o", 256'(busy), 256'(c.busy));
            end
            if (rst_n && fpu_valid && fready) begin
                if (issue_q.size() == 0) fail_now("issue");
                else begin
                    s = issue_q.pop_front();
                    check("fpu_tag_o", 256'(fpu_tag), 256'(s.tag));
                    check("fpu_payload_o", fpu_payload, s.pay);
                end
            end
            if (|rsp_valid) begin
                if (rsp_q.size() == 0) fail_now("response");
                else begin
                    r = rsp_q.pop_front();
                    check("rsp_route", 256'(rsp_valid), 256'(r.rv));
                    check("rsp_utag_o", 256'(rsp_utag), 256'(r.ut));
                    check("rsp_result_o", 256'(rsp_result), 256'(r.res));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            m_cnt[i] = 0;
            pay[i]   = '0;
            ut[i]    = '0;
        end
        // Reset with every input active: outputs must still read zero.
        vld = '1; fready = 1'b1; rvalid = 1'b1; rtag = '0; rsp_rdy = '1;
        #12;
        check("reset fpu_valid_o", 256'(fpu_valid), 256'(0));
        check("reset req_ready_o", 256'(req_ready), 256'(0));
        check("reset rsp_valid_o", 256'(rsp_valid), 256'(0));
        check("reset fpu_rready_o", 256'(fpu_rready), 256'(0));
        check("reset busy_o", 256'(busy), 256'(0));
        vld = '0; fready = 1'b0; rvalid = 1'b0; rsp_rdy = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run(4);

        // Both requesters streaming, FPU always ready, results returned promptly.
        p_req = 100; p_fr = 100; p_rv = 100; p_rr = 100; p_fl = 0;
        run(12);
        drain();

        // Back-pressure from the FPU pins the grant on requester 0.
        new_op(0, 4'h5);
        fready = 1'b0;
        tick();
        new_op(1, 4'ha);
        tick();
        tick();
        fready = 1'b1;
        tick();
        tick();
        drain();

        // Outstanding limit on requester 0, then one response unblocks it.
        p_rv = 0;
        fready = 1'b1;
        rsp_rdy = '1;
        for (int k = 0; k < MAX_OUTST; k++) begin
            new_op(0, UTAG_W'(k));
            tick();
        end
        new_op(0, 4'h4);
        new_op(1, 4'h7);
        tick();
        rvalid = 1'b1;
        rtag   = 5'b0_0011;
        rres   = RESULT_W'({$urandom, $urandom, $urandom});
        tick();
        tick();
        drain();

        // Result back-pressure on requester 1.
        p_rv = 0;
        new_op(1, 4'h9);
        fready = 1'b1;
        tick();
        rvalid  = 1'b1;
        rtag    = {1'b1, 4'h9};
        rres    = RESULT_W'({$urandom, $urandom, $urandom});
        rsp_rdy = 2'b01;
        tick();
        tick();
        rsp_rdy = 2'b11;
        tick();
        drain();

        // Counters at {3,2}, then a flush coincident with an issue.
        p_rv = 0;
        fready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            new_op(k % 2, UTAG_W'(k));
            tick();
        end
        new_op(0, 4'hc);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vld   = '0;
        tick();
        tick();
        drain();

        p_req = 60; p_fr = 70; p_rv = 50; p_rr = 70; p_fl = 2;
        run(3000);
        drain();
        flush = 1'b0;
        run(3);

        @(negedge clk);
        #1;
        check("issue queue empty", 256'(issue_q.size()), 256'(0));
        check("response queue empty", 256'(rsp_q.size()), 256'(0));
        check("cycle queue empty", 256'(cyc_q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
